// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared types and defaults for the APB master bridge.
package apb_master_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_state_e;

   localparam int DATA_W = 32;
   localparam logic [31:0] DEF_BASE_ADDR = 32'h1A10_0000;

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              err;
   } apb_rsp_t;

   // A single slave still gets a 1-bit index that must decode to zero.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: core request/response channel plus APB bus.
// master = bridge side; slave = requester and peripheral side.
interface apb_master_bridge_if
   import apb_master_pkg::*;
#(
   parameter int NUM_SLAVES     = 4,
   parameter int APB_ADDR_WIDTH = 12
);

   logic                  req_valid;
   logic                  req_ready;
   logic [DATA_W-1:0]     req_addr;
   logic                  req_we;
   logic [DATA_W-1:0]     req_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;

   logic [APB_ADDR_WIDTH-1:0] PADDR;
   logic [DATA_W-1:0]     PWDATA;
   logic                  PWRITE;
   logic                  PENABLE;
   logic [NUM_SLAVES-1:0] PSEL;

   logic [NUM_SLAVES-1:0][DATA_W-1:0] PRDATA;
   logic [NUM_SLAVES-1:0] PREADY;
   logic [NUM_SLAVES-1:0] PSLVERR;

   modport master (
      input  req_valid, req_addr, req_we, req_wdata,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      input  rsp_ready,
      output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      output req_valid, req_addr, req_we, req_wdata,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      output rsp_ready,
      input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_master_watchdog.sv
// apb_master_watchdog: counts stalled ACCESS cycles; at_limit flags that
// the current stalled cycle is the one that reaches TIMEOUT.
module apb_master_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic HCLK,
   input  logic HRESET,
   input  logic clr,
   input  logic en,
   output logic at_limit
);

   localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int LASTI = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] LAST = CW'(LASTI);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && (TIMEOUT != 0)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign at_limit = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-initiator APB master behind a valid/ready
// load/store port, with address decode and an ACCESS watchdog.
module apb_master_bridge
   import apb_master_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int NUM_SLAVES         = 4,
   parameter int APB_ADDR_WIDTH     = 12,
   parameter int TIMEOUT            = 255
) (
   input logic HCLK,
   input logic HRESET,
   apb_master_bridge_if.master bus
);

   localparam int IDX_W  = idx_width(NUM_SLAVES);
   localparam int TOP_LO = APB_ADDR_WIDTH + IDX_W;
   localparam logic [IDX_W:0] SLV_CNT = (IDX_W + 1)'(NUM_SLAVES);

   apb_state_e state_q, state_d;

   logic [IDX_W-1:0]          idx_q;
   logic [APB_ADDR_WIDTH-1:0] paddr_q;
   logic [DATA_W-1:0]         pwdata_q;
   logic                      pwrite_q;
   apb_rsp_t                  rsp_q, rsp_d;
   logic                      capture;

   logic [IDX_W-1:0] req_idx;
   logic             hit;
   logic             accept;
   logic             sel_ready;
   logic             sel_err;
   logic [DATA_W-1:0] sel_rdata;
   logic             wd_clr;
   logic             wd_en;
   logic             wd_limit;

   assign req_idx = bus.req_addr[APB_ADDR_WIDTH +: IDX_W];
   assign hit = (bus.req_addr[DATA_W-1:TOP_LO] == BASE_ADDR[DATA_W-1:TOP_LO])
              && ({1'b0, req_idx} < SLV_CNT);
   assign accept = (state_q == IDLE) && bus.req_valid;

   // Per-slave returns are muxed by the index latched at accept.
   assign sel_ready = bus.PREADY[idx_q];
   assign sel_err   = bus.PSLVERR[idx_q];
   assign sel_rdata = bus.PRDATA[idx_q];

   assign wd_clr = accept && hit;
   assign wd_en  = (state_q == ACCESS) && !sel_ready;

   apb_master_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wd (
      .HCLK     (HCLK),
      .HRESET   (HRESET),
      .clr      (wd_clr),
      .en       (wd_en),
      .at_limit (wd_limit)
   );

   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      rsp_d   = '0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (hit) begin
                  state_d = SETUP;
               end else begin
                  state_d   = RESP;
                  capture   = 1'b1;
                  rsp_d.err = 1'b1;
               end
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (sel_ready) begin
               state_d     = RESP;
               capture     = 1'b1;
               rsp_d.rdata = pwrite_q ? '0 : sel_rdata;
               rsp_d.err   = sel_err;
            end else if (wd_limit) begin
               state_d   = RESP;
               capture   = 1'b1;
               rsp_d.err = 1'b1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         idx_q    <= '0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pwrite_q <= 1'b0;
      end else if (accept) begin
         idx_q    <= req_idx;
         paddr_q  <= bus.req_addr[APB_ADDR_WIDTH-1:0];
         pwdata_q <= bus.req_wdata;
         pwrite_q <= bus.req_we;
      end
   end

   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         rsp_q <= '0;
      end else if (capture) begin
         rsp_q <= rsp_d;
      end
   end

   always_comb begin
      bus.PSEL = '0;
      if ((state_q == SETUP) || (state_q == ACCESS)) begin
         bus.PSEL[idx_q] = 1'b1;
      end
   end

   assign bus.PENABLE   = (state_q == ACCESS);
   assign bus.PADDR     = paddr_q;
   assign bus.PWDATA    = pwdata_q;
   assign bus.PWRITE    = pwrite_q;
   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rsp_q.rdata;
   assign bus.rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: vector table, hand sequences and random traffic
// checked against a transaction-level model of the bridge.
module tb_apb_master_bridge;
   import apb_master_pkg::*;

   localparam int NS = 4;
   localparam int AW = 12;
   localparam int TO = 4;
   localparam logic [31:0] BASE = 32'h1A10_0000;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          waits;
      logic        slverr;
      logic [31:0] prdata;
      int          hold;
      int          exp_lat;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   logic HCLK = 1'b0;
   logic HRESET;
   int total = 0;
   int bad = 0;
   int wait_cfg = 0;
   int acc_cnt = 0;
   vec_t tbl[10];

   apb_master_bridge_if #(.NUM_SLAVES(NS), .APB_ADDR_WIDTH(AW)) ifc ();

   apb_master_bridge #(
      .BASE_ADDR      (BASE),
      .NUM_SLAVES     (NS),
      .APB_ADDR_WIDTH (AW),
      .TIMEOUT        (TO)
   ) dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (ifc.master)
   );

   always #5 HCLK = ~HCLK;

   // Slave model: the selected slave holds PREADY low for wait_cfg cycles.
   always @(posedge HCLK)
      acc_cnt <= ((ifc.PSEL != '0) && ifc.PENABLE) ? acc_cnt + 1 : 0;

   always_comb begin
      for (int i = 0; i < NS; i++)
         ifc.PREADY[i] = ifc.PSEL[i] && ifc.PENABLE && (acc_cnt >= wait_cfg);
   end

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit in_window(input logic [31:0] a);
      return (a >= BASE) && ((a - BASE) < 32'(NS << AW));
   endfunction

   function automatic vec_t predict(input vec_t v);
      vec_t r;
      bit tout;
      int acc;
      r = v;
      if (!in_window(v.addr)) begin
         r.exp_lat   = 1;
         r.exp_err   = 1'b1;
         r.exp_rdata = 32'h0;
      end else begin
         tout        = (TO != 0) && (v.waits >= TO);
         acc         = tout ? TO : v.waits + 1;
         r.exp_lat   = 2 + acc;
         r.exp_err   = tout || v.slverr;
         r.exp_rdata = (tout || v.we) ? 32'h0 : v.prdata;
      end
      return r;
   endfunction

   task automatic run_txn(input vec_t v);
      bit hit;
      int idx;
      int cyc;
      logic [AW-1:0] off;
      logic [NS-1:0] sel;
      hit = in_window(v.addr);
      idx = hit ? int'((v.addr - BASE) >> AW) : 0;
      off = AW'(v.addr - BASE);
      sel = '0;
      if (hit) sel[idx] = 1'b1;
      wait_cfg = v.waits;
      for (int i = 0; i < NS; i++) begin
         ifc.PRDATA[i]  = $urandom;
         ifc.PSLVERR[i] = 1'($urandom);
      end
      if (hit) begin
         ifc.PRDATA[idx]  = v.prdata;
         ifc.PSLVERR[idx] = v.slverr;
      end
      ifc.req_addr  = v.addr;
      ifc.req_we    = v.we;
      ifc.req_wdata = v.wdata;
      ifc.req_valid = 1'b1;
      check("req_ready", 64'(ifc.req_ready), 64'(1));
      @(posedge HCLK); #1;
      ifc.req_valid = 1'b0;
      cyc = 1;
      while (!ifc.rsp_valid && cyc <= 40) begin
         if (hit)
            check("apb_bus",
                  64'({ifc.PSEL, ifc.PENABLE, ifc.PADDR, ifc.PWRITE, ifc.PWDATA}),
                  64'({sel, 1'(cyc > 1), off, v.we, v.wdata}));
         else
            check("apb_quiet", 64'({ifc.PSEL, ifc.PENABLE}), 64'(0));
         @(posedge HCLK); #1;
         cyc++;
      end
      check("latency", 64'(cyc), 64'(v.exp_lat));
      check("rsp_rdata", 64'(ifc.rsp_rdata), 64'(v.exp_rdata));
      check("rsp_err", 64'(ifc.rsp_err), 64'(v.exp_err));
      check("resp_apb_idle", 64'({ifc.PSEL, ifc.PENABLE}), 64'(0));
      for (int h = 0; h < v.hold; h++) begin
         ifc.req_addr  = 32'h2000_0000;
         ifc.req_valid = 1'b1;
         @(posedge HCLK); #1;
         check("hold_valid", 64'(ifc.rsp_valid), 64'(1));
         check("hold_data", 64'({ifc.rsp_rdata, ifc.rsp_err}),
               64'({v.exp_rdata, v.exp_err}));
         check("hold_ready", 64'(ifc.req_ready), 64'(0));
      end
      ifc.req_valid = 1'b0;
      ifc.rsp_ready = 1'b1;
      @(posedge HCLK); #1;
      ifc.rsp_ready = 1'b0;
      check("rsp_drop", 64'(ifc.rsp_valid), 64'(0));
      check("back_idle", 64'(ifc.req_ready), 64'(1));
   endtask

   initial begin
      vec_t v;
      //          addr          we    wdata         waits slverr prdata   hold lat err   rdata
      tbl[0] = '{32'h1A10_1008, 1'b1, 32'hDEAD_BEEF, 0,    1'b0, 32'h1234_5678, 0, 3, 1'b0, 32'h0};
      tbl[1] = '{32'h1A10_0004, 1'b0, 32'h0,         3,    1'b0, 32'h0000_00A5, 0, 6, 1'b0, 32'hA5};
      tbl[2] = '{32'h1A10_5000, 1'b0, 32'h0,         0,    1'b0, 32'h0,         0, 1, 1'b1, 32'h0};
      tbl[3] = '{32'h2000_0000, 1'b0, 32'h0,         0,    1'b0, 32'h0,         0, 1, 1'b1, 32'h0};
      tbl[4] = '{32'h1A10_2010, 1'b0, 32'h0,         1000, 1'b0, 32'h5555_5555, 0, 6, 1'b1, 32'h0};
      tbl[5] = '{32'h1A10_3000, 1'b1, 32'h0000_0011, 0,    1'b1, 32'h0,         0, 3, 1'b1, 32'h0};
      tbl[6] = '{32'h1A10_1FFC, 1'b0, 32'h0,         3,    1'b0, 32'hCAFE_F00D, 0, 6, 1'b0, 32'hCAFE_F00D};
      tbl[7] = '{32'h1A10_3FFC, 1'b0, 32'h0,         4,    1'b0, 32'h0000_0077, 0, 6, 1'b1, 32'h0};
      tbl[8] = '{32'h1A10_2020, 1'b0, 32'h0,         1,    1'b0, 32'h0BAD_F00D, 5, 4, 1'b0, 32'h0BAD_F00D};
      tbl[9] = '{32'h1A10_0000, 1'b1, 32'h0F0F_0F0F, 2,    1'b0, 32'hFFFF_FFFF, 2, 5, 1'b0, 32'h0};

      HRESET        = 1'b0;
      ifc.req_valid = 1'b0;
      ifc.req_addr  = 32'h0;
      ifc.req_we    = 1'b0;
      ifc.req_wdata = 32'h0;
      ifc.rsp_ready = 1'b0;
      ifc.PRDATA    = '0;
      ifc.PSLVERR   = '0;
      #1;
      check("rst_apb",
            64'({ifc.PSEL, ifc.PENABLE, ifc.PADDR, ifc.PWRITE, ifc.PWDATA}), 64'(0));
      check("rst_rsp", 64'({ifc.rsp_valid, ifc.rsp_err, ifc.rsp_rdata}), 64'(0));
      check("rst_ready", 64'(ifc.req_ready), 64'(1));
      @(posedge HCLK); #1;
      HRESET = 1'b1;
      @(posedge HCLK); #1;

      for (int i = 0; i < 10; i++) run_txn(tbl[i]);

      // Reset pulse in the middle of a stalled ACCESS phase.
      wait_cfg      = 1000;
      ifc.req_addr  = BASE + 32'h2040;
      ifc.req_we    = 1'b0;
      ifc.req_valid = 1'b1;
      @(posedge HCLK); #1;
      ifc.req_valid = 1'b0;
      @(posedge HCLK); #1;
      check("mid_access", 64'({ifc.PSEL, ifc.PENABLE}), 64'({4'b0100, 1'b1}));
      #2 HRESET = 1'b0;
      #1;
      check("rst_mid_apb", 64'({ifc.PSEL, ifc.PENABLE}), 64'(0));
      check("rst_mid_rsp", 64'(ifc.rsp_valid), 64'(0));
      check("rst_mid_ready", 64'(ifc.req_ready), 64'(1));
      @(posedge HCLK); #1;
      HRESET = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge HCLK); #1;
         check("no_rsp_after_rst", 64'(ifc.rsp_valid), 64'(0));
      end
      run_txn(tbl[1]);

      for (int n = 0; n < 40; n++) begin
         v = tbl[0];
         case ($urandom_range(3, 0))
            0: v.addr = $urandom;
            1: v.addr = BASE + 32'(NS << AW) + ($urandom_range(255, 0) << 2);
            default: v.addr = BASE + ($urandom_range(NS - 1, 0) << AW)
                            + ($urandom_range(1023, 0) << 2);
         endcase
         v.we     = 1'($urandom);
         v.wdata  = $urandom;
         v.waits  = $urandom_range(5, 0);
         v.slverr = v.we && ($urandom_range(3, 0) == 0);
         v.prdata = $urandom;
         v.hold   = $urandom_range(2, 0);
         v = predict(v);
         run_txn(v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-initiator APB master sitting between the core's load/store port and the APB peripheral slaves (timer, GPIO, UART, …). Accepts one word request at a time over a valid/ready handshake, decodes the target slave from the address, runs a SETUP/ACCESS APB transfer with wait-state support and a watchdog timeout, and returns read data plus an error flag over a valid/ready response channel.

## Interface
- `BASE_ADDR`, default 32'h1A10_0000: base of the APB window; bits above slave index must match.
- `NUM_SLAVES`, default 4: number of PSEL lines (≥1).
- `APB_ADDR_WIDTH`, default 12: per-slave address span (4 KB slaves).
- `TIMEOUT`, default 255: max ACCESS cycles without PREADY before abort; 0 disables.

Ports:
- `HCLK` in 1: clock.
- `HRESET` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: bridge can accept.
- `req_addr` in 32: byte address.
- `req_we` in 1: 1 write, 0 read.
- `req_wdata` in 32: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: requester takes response.
- `rsp_rdata` out 32: read data (0 for writes/errors).
- `rsp_err` out 1: decode error, PSLVERR, or timeout.
- `PADDR` out APB_ADDR_WIDTH: in-slave offset.
- `PWDATA` out 32; `PWRITE` out 1; `PENABLE` out 1.
- `PSEL` out NUM_SLAVES: one-hot select.
- `PRDATA` in NUM_SLAVES×32; `PREADY` in NUM_SLAVES; `PSLVERR` in NUM_SLAVES: per-slave returns, muxed internally by latched index.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state IDLE.
- `req_ready` = (state == IDLE). Accept on `req_valid && req_ready` at rising edge; latch addr, we, wdata, slave index.
- Decode: idx = req_addr[APB_ADDR_WIDTH +: clog2(NUM_SLAVES)]; hit iff upper bits equal BASE_ADDR's and idx < NUM_SLAVES.
- IDLE → SETUP on accepted hit; IDLE → RESP on accepted miss (err=1, rdata=0, no APB activity).
- SETUP (exactly 1 cycle): PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PWDATA valid → ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE=1. If PREADY[idx]: capture rdata = PWRITE ? 0 : PRDATA[idx], err = PSLVERR[idx] → RESP. Else increment watchdog; when count == TIMEOUT (TIMEOUT≠0): err=1, rdata=0 → RESP.
- RESP: rsp_valid=1, rsp_rdata/rsp_err stable; → IDLE when rsp_ready. No new request accepted until back in IDLE.
- PADDR, PWRITE, PWDATA hold latched values from SETUP until next accept (stable through ACCESS); PSEL all-zero and PENABLE=0 outside SETUP/ACCESS.
- PSLVERR/PRDATA ignored unless PREADY high in ACCESS.

## Timing
- Reset (HRESET low, async): state IDLE, PSEL=0, PENABLE=0, PADDR=0, PWDATA=0, PWRITE=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, watchdog=0; req_ready=1 follows IDLE.
- Reset mid-transfer: all outputs return to reset values immediately; transfer dropped, no response issued.
- Zero-wait-state hit: accept edge N; SETUP cycle N+1; ACCESS N+2; rsp_valid high in N+3. Each PREADY-low cycle adds 1.
- Decode miss: rsp_valid high the cycle after accept.
- Minimum request spacing 4 cycles (hit, rsp_ready held high); 2 cycles (miss).
- Watchdog width clog2(TIMEOUT+1); cleared on entry to SETUP; PREADY in the same cycle count reaches TIMEOUT wins (normal completion).
- rsp_valid held with stable data while rsp_ready low; no timeout in RESP.

## Structure
- `apb_master_pkg`: state enum (IDLE/SETUP/ACCESS/RESP), default BASE_ADDR, data width constant 32.
- Sub-module `apb_master_watchdog`: clear/enable/expire counter parameterised by TIMEOUT; remainder in one module.

## Test plan
- Write 32'hDEAD_BEEF to BASE_ADDR+32'h1008, slave 1 PREADY=1 → PSEL=4'b0010, PADDR=12'h008, PWRITE=1, SETUP then ACCESS, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read BASE_ADDR+32'h0004, slave 0 PREADY low 3 cycles then high with PRDATA=32'h0000_00A5 → rsp_rdata=32'hA5, rsp_valid 6 cycles after accept, PADDR/PENABLE stable during waits.
- Read BASE_ADDR+32'h5000 (idx 5 ≥ 4) and 32'h2000_0000 → no PSEL asserted, rsp_err=1 next cycle.
- TIMEOUT=4, slave 2 PREADY stuck low → abort after 4 ACCESS cycles, PSEL/PENABLE drop, rsp_err=1, rdata=0; PSLVERR=1 with PREADY=1 on slave 3 → rsp_err=1.
- rsp_ready held low 5 cycles → rsp_valid/rdata stable, req_ready=0, second request not accepted until handshake.
- HRESET pulsed low during ACCESS → PSEL/PENABLE 0 immediately, no rsp_valid; next request completes normally.
